// File: rtl/xrv_pkg.sv
// Shared decode definitions: RV32I opcodes, decode FSM states, immediate formats.
package xrv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_REG    = 7'h33;

    // funct7 value that marks an RV32M op inside the op_reg class
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [1:0] {RUN, WAIT_LS, WAIT_MD} id_state_t;

    typedef enum logic [2:0] {I, S, B, U, J} imm_fmt_t;

    // Immediate format implied by the major opcode; op_reg has none, I is harmless.
    function automatic imm_fmt_t imm_fmt_of(logic [6:0] opc);
        imm_fmt_t fmt;
        fmt = I;
        case (opc)
            OPC_LUI, OPC_AUIPC: fmt = U;
            OPC_JAL:            fmt = J;
            OPC_BRANCH:         fmt = B;
            OPC_STORE:          fmt = S;
            default:            fmt = I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/xrv_imm_gen.sv
// Combinational immediate generator: selects and sign-extends the immediate of one format.
module xrv_imm_gen
    import xrv_pkg::*;
(
    input  logic [31:7] i_instr,
    input  logic [2:0]  i_fmt,
    output logic [31:0] o_imm
);

    // Reassemble the scattered immediate bits for the requested format.
    always_comb begin
        o_imm = '0;
        case (i_fmt)
            I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
            U: o_imm = {i_instr[31:12], 12'h000};
            J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/xrv_id.sv
// RV32I decode stage: handshake with fetch, decode, PC-relative targets and pipeline interlocks.
module xrv_id
    import xrv_pkg::*;
#(
    parameter int unsigned EN_MULT_DIV     = 0,
    parameter int unsigned TWO_STAGE_ALU   = 0,
    parameter int unsigned RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        ex_jmp,
    input  logic        ls_done,
    input  logic        mult_div_done,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_pc_auipc,
    output logic [31:0] ex_pc_jmp,
    output logic [31:0] ex_pc_branch,
    output logic        op_lui,
    output logic        op_auipc,
    output logic        op_jal,
    output logic        op_jalr,
    output logic        op_branch,
    output logic        op_load,
    output logic        op_store,
    output logic        op_imm,
    output logic        op_reg,
    output logic        op_is_compressed,
    output logic [31:0] imm_signed,
    output logic [31:0] imm_unsigned,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic [4:0]  dest,
    output logic [6:0]  funct7,
    output logic [2:0]  funct3,
    output logic        illegal_instr
);

    localparam bit MD_EN = (EN_MULT_DIV != 0);
    localparam bit ALU2  = (TWO_STAGE_ALU != 0);

    logic w_unused_reset_pc;
    assign w_unused_reset_pc = (RESET_PC_UNUSED != 0);

    id_state_t r_state, w_state_d;
    logic      r_bubble, w_bubble_d;
    logic      r_ls_first, w_ls_first_d;

    logic [6:0] w_opc;
    logic w_op_lui, w_op_auipc, w_op_jal, w_op_jalr, w_op_branch;
    logic w_op_load, w_op_store, w_op_imm, w_op_reg;
    logic w_is_mop, w_legal, w_accept, w_issue, w_is_mem;
    imm_fmt_t    w_fmt;
    logic [31:0] w_imm, w_imm_b, w_imm_u;

    assign w_opc       = if_instr[6:0];
    // Every legal opcode ends in 2'b11, so a full 7-bit match also rejects compressed words.
    assign w_op_lui    = (w_opc == OPC_LUI);
    assign w_op_auipc  = (w_opc == OPC_AUIPC);
    assign w_op_jal    = (w_opc == OPC_JAL);
    assign w_op_jalr   = (w_opc == OPC_JALR);
    assign w_op_branch = (w_opc == OPC_BRANCH);
    assign w_op_load   = (w_opc == OPC_LOAD);
    assign w_op_store  = (w_opc == OPC_STORE);
    assign w_op_imm    = (w_opc == OPC_IMM);
    assign w_op_reg    = (w_opc == OPC_REG);

    assign w_is_mop = w_op_reg & (if_instr[31:25] == FUNCT7_MULDIV);
    assign w_is_mem = w_op_load | w_op_store;
    assign w_legal  = (w_op_lui | w_op_auipc | w_op_jal | w_op_jalr | w_op_branch |
                       w_op_load | w_op_store | w_op_imm | w_op_reg) & ~(w_is_mop & ~MD_EN);

    assign if_ready = (r_state == RUN) & ~r_bubble;
    assign w_accept = if_valid & if_ready & ~ex_jmp;
    assign w_issue  = w_accept & w_legal;

    assign w_fmt = imm_fmt_of(w_opc);

    xrv_imm_gen u_imm_sel (
        .i_instr (if_instr[31:7]),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    // Branch and AUIPC targets are precomputed for every word regardless of class.
    xrv_imm_gen u_imm_b (
        .i_instr (if_instr[31:7]),
        .i_fmt   (B),
        .o_imm   (w_imm_b)
    );

    xrv_imm_gen u_imm_u (
        .i_instr (if_instr[31:7]),
        .i_fmt   (U),
        .o_imm   (w_imm_u)
    );

    // Interlock next-state: memory and mult/div waits, one-cycle ALU bubble.
    always_comb begin
        w_state_d    = r_state;
        w_bubble_d   = ALU2 & w_issue & (w_op_imm | (w_op_reg & ~w_is_mop));
        w_ls_first_d = w_issue & w_is_mem;
        case (r_state)
            RUN: begin
                if (w_issue && w_is_mem) begin
                    w_state_d = WAIT_LS;
                end else if (w_issue && w_is_mop) begin
                    w_state_d = WAIT_MD;
                end
            end
            // A jump in the first wait cycle means execute squashed the memory op.
            WAIT_LS: if (ls_done || (r_ls_first && ex_jmp)) w_state_d = RUN;
            WAIT_MD: if (mult_div_done) w_state_d = RUN;
            default: w_state_d = RUN;
        endcase
    end

    // Interlock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_bubble   <= 1'b0;
            r_ls_first <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_bubble   <= w_bubble_d;
            r_ls_first <= w_ls_first_d;
        end
    end

    // Decoded fields load only on issue and otherwise hold for execute's delayed writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            illegal_instr <= 1'b0;
            ex_pc         <= '0;
            ex_pc_auipc   <= '0;
            ex_pc_jmp     <= '0;
            ex_pc_branch  <= '0;
            {op_lui, op_auipc, op_jal, op_jalr, op_branch,
             op_load, op_store, op_imm, op_reg} <= '0;
            imm_signed    <= '0;
            src1          <= '0;
            src2          <= '0;
            dest          <= '0;
            funct7        <= '0;
            funct3        <= '0;
        end else begin
            ex_valid      <= w_issue;
            illegal_instr <= w_accept & ~w_legal;
            if (w_issue) begin
                ex_pc        <= if_pc;
                ex_pc_auipc  <= if_pc + w_imm_u;
                ex_pc_jmp    <= if_pc + 32'd4;
                ex_pc_branch <= if_pc + w_imm_b;
                {op_lui, op_auipc, op_jal, op_jalr, op_branch,
                 op_load, op_store, op_imm, op_reg} <= {w_op_lui, w_op_auipc, w_op_jal,
                    w_op_jalr, w_op_branch, w_op_load, w_op_store, w_op_imm, w_op_reg};
                imm_signed   <= w_imm;
                src1         <= if_instr[19:15];
                src2         <= if_instr[24:20];
                dest         <= if_instr[11:7];
                funct7       <= if_instr[31:25];
                funct3       <= if_instr[14:12];
            end
        end
    end

    assign op_is_compressed = 1'b0;
    assign imm_unsigned     = imm_signed;

endmodule

// File: tb/tb_xrv_id.sv
// Bench for xrv_id: directed scenarios plus a randomized stream against a behavioural model.
`timescale 1ns/1ps
module tb_xrv_id;

    typedef struct packed {
        logic        valid;
        logic        ill;
        logic        cmp;
        logic [31:0] pc;
        logic [31:0] pc_auipc;
        logic [31:0] pc_jmp;
        logic [31:0] pc_branch;
        logic [8:0]  ops;
        logic [31:0] imm;
        logic [31:0] immu;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  d;
        logic [6:0]  f7;
        logic [2:0]  f3;
    } obs_t;

    typedef struct packed {
        obs_t o;
        bit   ls_pend;
        bit   ls_first;
        bit   md_pend;
        bit   bub;
    } model_t;

    localparam int K_LUI = 1, K_AUIPC = 2, K_JAL = 3, K_JALR = 4, K_BRANCH = 5;
    localparam int K_LOAD = 6, K_STORE = 7, K_IMM = 8, K_REG = 9, K_MOP = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT a: defaults (no M extension, single-stage ALU)
    logic        a_if_valid = 0, a_ex_jmp = 0, a_ls_done = 0, a_md_done = 0;
    logic [31:0] a_if_instr = 0, a_if_pc = 0;
    logic        a_if_ready, a_ex_valid, a_cmp, a_ill;
    logic [31:0] a_ex_pc, a_pc_auipc, a_pc_jmp, a_pc_branch, a_imm, a_immu;
    logic        a_lui, a_auipc, a_jal, a_jalr, a_branch, a_load, a_store, a_opimm, a_opreg;
    logic [4:0]  a_src1, a_src2, a_dest;
    logic [6:0]  a_funct7;
    logic [2:0]  a_funct3;

    // DUT b: M extension and two-stage ALU enabled
    logic        b_if_valid = 0, b_ex_jmp = 0, b_ls_done = 0, b_md_done = 0;
    logic [31:0] b_if_instr = 0, b_if_pc = 0;
    logic        b_if_ready, b_ex_valid, b_cmp, b_ill;
    logic [31:0] b_ex_pc, b_pc_auipc, b_pc_jmp, b_pc_branch, b_imm, b_immu;
    logic        b_lui, b_auipc, b_jal, b_jalr, b_branch, b_load, b_store, b_opimm, b_opreg;
    logic [4:0]  b_src1, b_src2, b_dest;
    logic [6:0]  b_funct7;
    logic [2:0]  b_funct3;

    xrv_id #(.EN_MULT_DIV(0), .TWO_STAGE_ALU(0), .RESET_PC_UNUSED(0)) u_dut_a (
        .clk(clk), .rst(rst), .if_valid(a_if_valid), .if_instr(a_if_instr), .if_pc(a_if_pc),
        .if_ready(a_if_ready), .ex_jmp(a_ex_jmp), .ls_done(a_ls_done),
        .mult_div_done(a_md_done), .ex_valid(a_ex_valid), .ex_pc(a_ex_pc),
        .ex_pc_auipc(a_pc_auipc), .ex_pc_jmp(a_pc_jmp), .ex_pc_branch(a_pc_branch),
        .op_lui(a_lui), .op_auipc(a_auipc), .op_jal(a_jal), .op_jalr(a_jalr),
        .op_branch(a_branch), .op_load(a_load), .op_store(a_store), .op_imm(a_opimm),
        .op_reg(a_opreg), .op_is_compressed(a_cmp), .imm_signed(a_imm), .imm_unsigned(a_immu),
        .src1(a_src1), .src2(a_src2), .dest(a_dest), .funct7(a_funct7), .funct3(a_funct3),
        .illegal_instr(a_ill)
    );

    xrv_id #(.EN_MULT_DIV(1), .TWO_STAGE_ALU(1), .RESET_PC_UNUSED(0)) u_dut_b (
        .clk(clk), .rst(rst), .if_valid(b_if_valid), .if_instr(b_if_instr), .if_pc(b_if_pc),
        .if_ready(b_if_ready), .ex_jmp(b_ex_jmp), .ls_done(b_ls_done),
        .mult_div_done(b_md_done), .ex_valid(b_ex_valid), .ex_pc(b_ex_pc),
        .ex_pc_auipc(b_pc_auipc), .ex_pc_jmp(b_pc_jmp), .ex_pc_branch(b_pc_branch),
        .op_lui(b_lui), .op_auipc(b_auipc), .op_jal(b_jal), .op_jalr(b_jalr),
        .op_branch(b_branch), .op_load(b_load), .op_store(b_store), .op_imm(b_opimm),
        .op_reg(b_opreg), .op_is_compressed(b_cmp), .imm_signed(b_imm), .imm_unsigned(b_immu),
        .src1(b_src1), .src2(b_src2), .dest(b_dest), .funct7(b_funct7), .funct3(b_funct3),
        .illegal_instr(b_ill)
    );

    obs_t a_obs, b_obs;
    always_comb a_obs = {a_ex_valid, a_ill, a_cmp, a_ex_pc, a_pc_auipc, a_pc_jmp, a_pc_branch,
                         a_lui, a_auipc, a_jal, a_jalr, a_branch, a_load, a_store, a_opimm,
                         a_opreg, a_imm, a_immu, a_src1, a_src2, a_dest, a_funct7, a_funct3};
    always_comb b_obs = {b_ex_valid, b_ill, b_cmp, b_ex_pc, b_pc_auipc, b_pc_jmp, b_pc_branch,
                         b_lui, b_auipc, b_jal, b_jalr, b_branch, b_load, b_store, b_opimm,
                         b_opreg, b_imm, b_immu, b_src1, b_src2, b_dest, b_funct7, b_funct3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int classify(logic [31:0] w, bit md_en);
        case (w[6:0])
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            7'h6F: return K_JAL;
            7'h67: return K_JALR;
            7'h63: return K_BRANCH;
            7'h03: return K_LOAD;
            7'h23: return K_STORE;
            7'h13: return K_IMM;
            7'h33: begin
                if (w[31:25] == 7'd1) return md_en ? K_MOP : 0;
                return K_REG;
            end
            default: return 0;
        endcase
    endfunction

    function automatic obs_t decode(logic [31:0] w, logic [31:0] pc, int k);
        obs_t o;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        iimm = 32'($signed(w) >>> 20);
        simm = (32'($signed(w) >>> 20) & 32'hFFFF_FFE0) | ((w >> 7) & 32'h1F);
        bimm = (32'($signed(w) >>> 19) & 32'hFFFF_F000) | ((w >> 20) & 32'h7E0) |
               ((w >> 7) & 32'h1E) | ((w << 4) & 32'h800);
        uimm = w & 32'hFFFF_F000;
        jimm = (32'($signed(w) >>> 11) & 32'hFFF0_0000) | (w & 32'h000F_F000) |
               ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7FE);
        o = '0;
        o.valid     = 1'b1;
        o.pc        = pc;
        o.pc_auipc  = pc + uimm;
        o.pc_jmp    = pc + 32'd4;
        o.pc_branch = pc + bimm;
        o.ops       = 9'b1 << (9 - ((k == K_MOP) ? K_REG : k));
        case (k)
            K_LUI, K_AUIPC: o.imm = uimm;
            K_JAL:          o.imm = jimm;
            K_BRANCH:       o.imm = bimm;
            K_STORE:        o.imm = simm;
            default:        o.imm = iimm;
        endcase
        o.immu = o.imm;
        o.s1   = w[19:15];
        o.s2   = w[24:20];
        o.d    = w[11:7];
        o.f7   = w[31:25];
        o.f3   = w[14:12];
        return o;
    endfunction

    function automatic bit model_ready(model_t m);
        return !m.ls_pend && !m.md_pend && !m.bub;
    endfunction

    // Advances the model by one clock given the inputs presented in that cycle.
    task automatic model_step(input bit alu2, input bit md_en, input logic v,
                              input logic [31:0] ins, input logic [31:0] pc, input logic jmp,
                              input logic lsd, input logic mdd, inout model_t m);
        bit acc;
        int k;
        acc = v && model_ready(m) && !jmp;
        m.o.valid = 1'b0;
        m.o.ill   = 1'b0;
        if (m.ls_pend && (lsd || (jmp && m.ls_first))) m.ls_pend = 1'b0;
        if (m.md_pend && mdd) m.md_pend = 1'b0;
        m.ls_first = 1'b0;
        m.bub      = 1'b0;
        if (acc) begin
            k = classify(ins, md_en);
            if (k == 0) begin
                m.o.ill = 1'b1;
            end else begin
                m.o = decode(ins, pc, k);
                if (k == K_LOAD || k == K_STORE) begin
                    m.ls_pend  = 1'b1;
                    m.ls_first = 1'b1;
                end
                if (k == K_MOP) m.md_pend = 1'b1;
                if (alu2 && (k == K_IMM || k == K_REG)) m.bub = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;
            9: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
            10: w[6:0] = 7'h0F;
            default: w[1:0] = 2'b00;
        endcase
        return w;
    endfunction

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++; if (a_obs !== '0) begin n_err++;
            $display("FAIL reset_a: got %h want 0", a_obs); end
        n_cmp++; if (b_obs !== '0) begin n_err++;
            $display("FAIL reset_b: got %h want 0", b_obs); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({a_if_ready, b_if_ready} !== 2'b11) begin n_err++;
            $display("FAIL reset_ready: got %b want 11", {a_if_ready, b_if_ready}); end
    endtask

    task automatic test_addi();
        a_if_valid = 1; a_if_instr = 32'h0050_0093; a_if_pc = 32'h100;
        n_cmp++; if (a_ex_valid !== 1'b0) begin n_err++;
            $display("FAIL addi_pre_valid: got %b want 0", a_ex_valid); end
        tick();
        a_if_valid = 0;
        n_cmp++; if ({a_ex_valid, a_opimm, a_imm, a_dest, a_src1, a_pc_jmp} !==
                     {1'b1, 1'b1, 32'd5, 5'd1, 5'd0, 32'h104}) begin n_err++;
            $display("FAIL addi_fields: got v=%b imm=%b %h d=%0d s1=%0d pcj=%h want 1 1 5 1 0 104",
                     a_ex_valid, a_opimm, a_imm, a_dest, a_src1, a_pc_jmp); end
        tick();
        n_cmp++; if ({a_ex_valid, a_dest} !== {1'b0, 5'd1}) begin n_err++;
            $display("FAIL addi_hold: got v=%b d=%0d want 0 1", a_ex_valid, a_dest); end
    endtask

    task automatic test_branch_squash();
        a_if_valid = 1; a_if_instr = 32'hFE00_0CE3; a_if_pc = 32'h200;
        tick();
        n_cmp++; if ({a_ex_valid, a_branch, a_imm, a_pc_branch} !==
                     {1'b1, 1'b1, 32'hFFFF_FFF8, 32'h1F8}) begin n_err++;
            $display("FAIL beq_fields: got v=%b br=%b imm=%h pcb=%h want 1 1 fffffff8 1f8",
                     a_ex_valid, a_branch, a_imm, a_pc_branch); end
        a_ex_jmp = 1; a_if_instr = 32'h0050_0093; a_if_pc = 32'h204;
        tick();
        a_ex_jmp = 0; a_if_valid = 0;
        n_cmp++; if (a_ex_valid !== 1'b0) begin n_err++;
            $display("FAIL beq_squash: got %b want 0", a_ex_valid); end
    endtask

    task automatic test_load_stall();
        a_if_valid = 1; a_if_instr = 32'h0000_A103; a_if_pc = 32'h300;
        tick();
        n_cmp++; if ({a_ex_valid, a_load, a_dest, a_if_ready} !== {1'b1, 1'b1, 5'd2, 1'b0})
        begin n_err++;
            $display("FAIL lw_issue: got v=%b ld=%b d=%0d rdy=%b want 1 1 2 0",
                     a_ex_valid, a_load, a_dest, a_if_ready); end
        a_if_instr = 32'h0020_81B3; a_if_pc = 32'h304;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if ({a_ex_valid, a_if_ready} !== 2'b00) begin n_err++;
                $display("FAIL lw_wait: got v=%b rdy=%b want 0 0", a_ex_valid, a_if_ready); end
        end
        tick();
        a_ls_done = 1;
        n_cmp++; if (a_if_ready !== 1'b0) begin n_err++;
            $display("FAIL lw_done_cycle_ready: got %b want 0", a_if_ready); end
        tick();
        a_ls_done = 0;
        n_cmp++; if (a_if_ready !== 1'b1) begin n_err++;
            $display("FAIL lw_resume_ready: got %b want 1", a_if_ready); end
        tick();
        a_if_valid = 0;
        n_cmp++; if ({a_ex_valid, a_opreg, a_dest} !== {1'b1, 1'b1, 5'd3}) begin n_err++;
            $display("FAIL add_after_lw: got v=%b reg=%b d=%0d want 1 1 3",
                     a_ex_valid, a_opreg, a_dest); end
    endtask

    task automatic test_ls_jmp();
        a_if_valid = 1; a_if_instr = 32'h0020_A023; a_if_pc = 32'h400;
        tick();
        a_ex_jmp = 1; a_if_instr = 32'h0050_0093; a_if_pc = 32'h404;
        n_cmp++; if ({a_ex_valid, a_store, a_if_ready} !== 3'b110) begin n_err++;
            $display("FAIL sw_issue: got v=%b st=%b rdy=%b want 1 1 0",
                     a_ex_valid, a_store, a_if_ready); end
        tick();
        a_ex_jmp = 0; a_if_pc = 32'h800;
        n_cmp++; if (a_if_ready !== 1'b1) begin n_err++;
            $display("FAIL sw_jmp_release: got %b want 1", a_if_ready); end
        tick();
        a_if_valid = 0;
        n_cmp++; if ({a_ex_valid, a_ex_pc} !== {1'b1, 32'h800}) begin n_err++;
            $display("FAIL sw_jmp_next_issue: got v=%b pc=%h want 1 800", a_ex_valid, a_ex_pc);
        end
    endtask

    task automatic test_illegal();
        a_if_valid = 1; a_if_instr = 32'h0070_0293; a_if_pc = 32'h500;
        tick();
        a_if_instr = 32'h0000_0001;
        tick();
        n_cmp++; if ({a_ill, a_ex_valid, a_dest} !== {1'b1, 1'b0, 5'd5}) begin n_err++;
            $display("FAIL illegal_word: got ill=%b v=%b d=%0d want 1 0 5",
                     a_ill, a_ex_valid, a_dest); end
        a_if_instr = 32'h0231_00B3;
        tick();
        a_if_valid = 0;
        n_cmp++; if ({a_ill, a_ex_valid, a_dest} !== {1'b1, 1'b0, 5'd5}) begin n_err++;
            $display("FAIL illegal_mul: got ill=%b v=%b d=%0d want 1 0 5",
                     a_ill, a_ex_valid, a_dest); end
        tick();
        n_cmp++; if (a_ill !== 1'b0) begin n_err++;
            $display("FAIL illegal_pulse: got %b want 0", a_ill); end
    endtask

    task automatic test_two_stage();
        b_if_valid = 1; b_if_instr = 32'h0050_0093; b_if_pc = 32'h600;
        tick();
        b_if_instr = 32'h0070_0293; b_if_pc = 32'h604;
        n_cmp++; if ({b_ex_valid, b_dest, b_if_ready} !== {1'b1, 5'd1, 1'b0}) begin n_err++;
            $display("FAIL alu2_first: got v=%b d=%0d rdy=%b want 1 1 0",
                     b_ex_valid, b_dest, b_if_ready); end
        tick();
        n_cmp++; if ({b_ex_valid, b_dest, b_if_ready} !== {1'b0, 5'd1, 1'b1}) begin n_err++;
            $display("FAIL alu2_bubble: got v=%b d=%0d rdy=%b want 0 1 1",
                     b_ex_valid, b_dest, b_if_ready); end
        tick();
        b_if_valid = 0;
        n_cmp++; if ({b_ex_valid, b_dest, b_imm} !== {1'b1, 5'd5, 32'd7}) begin n_err++;
            $display("FAIL alu2_second: got v=%b d=%0d imm=%h want 1 5 7",
                     b_ex_valid, b_dest, b_imm); end
        tick();
    endtask

    task automatic test_md_reset();
        b_if_valid = 1; b_if_instr = 32'h0231_00B3; b_if_pc = 32'h700;
        tick();
        b_if_valid = 0;
        n_cmp++; if ({b_ex_valid, b_ill, b_opreg, b_if_ready} !== 4'b1010) begin n_err++;
            $display("FAIL mul_issue: got v=%b ill=%b reg=%b rdy=%b want 1 0 1 0",
                     b_ex_valid, b_ill, b_opreg, b_if_ready); end
        tick();
        n_cmp++; if (b_if_ready !== 1'b0) begin n_err++;
            $display("FAIL mul_wait: got %b want 0", b_if_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (b_obs !== '0) begin n_err++;
            $display("FAIL mul_reset_outputs: got %h want 0", b_obs); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (b_if_ready !== 1'b1) begin n_err++;
            $display("FAIL mul_reset_ready: got %b want 1", b_if_ready); end
        b_if_valid = 1; b_if_instr = 32'h0050_0093; b_if_pc = 32'h900;
        tick();
        b_if_valid = 0;
        n_cmp++; if ({b_ex_valid, b_dest} !== {1'b1, 5'd1}) begin n_err++;
            $display("FAIL mul_reset_issue: got v=%b d=%0d want 1 1", b_ex_valid, b_dest); end
    endtask

    task automatic test_random();
        model_t ma, mb;
        rst = 1'b1;
        a_if_valid = 0; a_ex_jmp = 0; a_ls_done = 0; a_md_done = 0;
        b_if_valid = 0; b_ex_jmp = 0; b_ls_done = 0; b_md_done = 0;
        tick();
        rst = 1'b0;
        ma = '0;
        mb = '0;
        for (int c = 0; c < 600; c++) begin
            n_cmp++; if (a_obs !== ma.o) begin n_err++;
                $display("FAIL rand_a_out cyc %0d: got %h want %h", c, a_obs, ma.o); end
            n_cmp++; if (a_if_ready !== model_ready(ma)) begin n_err++;
                $display("FAIL rand_a_ready cyc %0d: got %b want %b", c, a_if_ready,
                         model_ready(ma)); end
            n_cmp++; if (b_obs !== mb.o) begin n_err++;
                $display("FAIL rand_b_out cyc %0d: got %h want %h", c, b_obs, mb.o); end
            n_cmp++; if (b_if_ready !== model_ready(mb)) begin n_err++;
                $display("FAIL rand_b_ready cyc %0d: got %b want %b", c, b_if_ready,
                         model_ready(mb)); end
            a_if_valid = ($urandom_range(0, 3) != 0);
            a_if_instr = rand_instr();
            a_if_pc    = $urandom;
            a_ex_jmp   = ($urandom_range(0, 6) == 0);
            a_ls_done  = ($urandom_range(0, 3) == 0);
            a_md_done  = ($urandom_range(0, 3) == 0);
            b_if_valid = ($urandom_range(0, 3) != 0);
            b_if_instr = rand_instr();
            b_if_pc    = $urandom;
            b_ex_jmp   = ($urandom_range(0, 6) == 0);
            b_ls_done  = ($urandom_range(0, 3) == 0);
            b_md_done  = ($urandom_range(0, 3) == 0);
            model_step(1'b0, 1'b0, a_if_valid, a_if_instr, a_if_pc, a_ex_jmp, a_ls_done,
                       a_md_done, ma);
            model_step(1'b1, 1'b1, b_if_valid, b_if_instr, b_if_pc, b_ex_jmp, b_ls_done,
                       b_md_done, mb);
            tick();
        end
        a_if_valid = 0;
        b_if_valid = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch_squash();
        test_load_stall();
        test_ls_jmp();
        test_illegal();
        test_two_stage();
        test_md_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
